// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch FIFO between combinational IMem and decode, flushed on redirect.
// Define FETCH_QUEUE_STATS_EN to add the FlushCnt/StallCnt statistics ports.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     Redirect,
    input  logic [31:0]              RedirectPC,
    input  logic                     Stall,
    output logic [31:0]              IMemAddr,
    input  logic [31:0]              IMemData,
    output logic [31:0]              Inst_de,
    output logic [31:0]              PC_de,
    output logic [31:0]              PCInc_de,
    output logic                     Valid_de,
    output logic [$clog2(DEPTH):0]   Count
`ifdef FETCH_QUEUE_STATS_EN
    ,
    output logic [15:0]              FlushCnt,
    output logic [15:0]              StallCnt
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   inst_mem [DEPTH];
    logic [AW-1:0] rd, wr;
    logic [31:0]   fpc;
    logic          pop, push;
    assign Valid_de = Count != '0;
    assign pop      = Valid_de & ~Stall;
    assign push     = ((Count < FULL) | pop) & ~Redirect;
    assign IMemAddr = fpc;
    assign Inst_de  = Valid_de ? inst_mem[rd] : NOP_INST;
    assign PC_de    = Valid_de ? pc_mem[rd] : 32'h0;
    assign PCInc_de = Valid_de ? pc_mem[rd] + 32'd4 : 32'h0;
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            fpc   <= RESET_PC;
            rd    <= '0;
            wr    <= '0;
            Count <= '0;
        end else if (Redirect) begin
            fpc   <= {RedirectPC[31:2], 2'b00};
            rd    <= '0;
            wr    <= '0;
            Count <= '0;
        end else begin
            if (push) begin
                fpc <= fpc + 32'd4;
                wr  <= wr + AW'(1);
            end
            if (pop)
                rd <= rd + AW'(1);
            Count <= Count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    // Payload needs no reset: head outputs are masked by Valid_de while empty.
    always_ff @(posedge Clk) begin
        if (push) begin
            pc_mem[wr]   <= fpc;
            inst_mem[wr] <= IMemData;
        end
    end
`ifdef FETCH_QUEUE_STATS_EN
    logic [16:0] flush_sum;
    assign flush_sum = {1'b0, FlushCnt} + 17'(Count);
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            FlushCnt <= '0;
            StallCnt <= '0;
        end else begin
            if (Redirect)
                FlushCnt <= flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
            if (Valid_de & Stall & (StallCnt != 16'hFFFF))
                StallCnt <= StallCnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios plus random redirect/stall traffic against a queue-based model.
module tb_fetch_queue;
    logic        Clk = 1'b0, Rst = 1'b1, Redirect = 1'b0, Stall = 1'b0;
    logic [31:0] RedirectPC = 32'h0;
    logic [31:0] IMemAddr, IMemData, Inst_de, PC_de, PCInc_de;
    logic        Valid_de;
    logic [2:0]  Count;
`ifdef FETCH_QUEUE_STATS_EN
    logic [15:0] FlushCnt, StallCnt;
`endif
    int errors = 0, checks = 0;
    logic [31:0] q[$];
    logic [31:0] mfpc;
    int mflush, mstall;

    fetch_queue dut (
        .Clk(Clk), .Rst(Rst), .Redirect(Redirect), .RedirectPC(RedirectPC), .Stall(Stall),
        .IMemAddr(IMemAddr), .IMemData(IMemData), .Inst_de(Inst_de), .PC_de(PC_de),
        .PCInc_de(PCInc_de), .Valid_de(Valid_de), .Count(Count)
`ifdef FETCH_QUEUE_STATS_EN
        , .FlushCnt(FlushCnt), .StallCnt(StallCnt)
`endif
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
    endfunction
    assign IMemData = imem(IMemAddr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        mfpc   = 32'h0;
        mflush = 0;
        mstall = 0;
    endtask

    task automatic compare_all();
        int n = q.size();
        check("count", 32'(Count), 32'(n));
        check("valid", 32'(Valid_de), 32'(n != 0));
        check("pc_de", PC_de, n != 0 ? q[0] : 32'h0);
        check("pcinc_de", PCInc_de, n != 0 ? q[0] + 32'd4 : 32'h0);
        check("inst_de", Inst_de, n != 0 ? imem(q[0]) : 32'h13);
        check("imem_addr", IMemAddr, mfpc);
`ifdef FETCH_QUEUE_STATS_EN
        check("flush_cnt", 32'(FlushCnt), 32'(mflush));
        check("stall_cnt", 32'(StallCnt), 32'(mstall));
`endif
    endtask

    // Called 1 time unit after a rising edge; returns at the same phase of the next cycle.
    task automatic cyc(input logic r, input logic [31:0] rp, input logic s);
        int  n;
        bit  was_full, popped;
        Redirect   = r;
        RedirectPC = rp;
        Stall      = s;
        #1;
        compare_all();
        n = q.size();
        if (n > 0 && s && mstall < 65535) mstall++;
        if (r) begin
            mflush = (mflush + n > 65535) ? 65535 : mflush + n;
            q.delete();
            mfpc = {rp[31:2], 2'b00};
        end else begin
            was_full = (n == 4);
            popped   = (n > 0) && !s;
            if (popped) void'(q.pop_front());
            if (!was_full || popped) begin
                q.push_back(mfpc);
                mfpc = mfpc + 32'd4;
            end
        end
        @(posedge Clk);
        #1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        compare_all();
        Rst = 1'b0;
        // sequential streaming
        repeat (8) cyc(1'b0, 32'h0, 1'b0);
        // back-pressure until full, then release
        repeat (6) cyc(1'b0, 32'h0, 1'b1);
        repeat (6) cyc(1'b0, 32'h0, 1'b0);
        // redirect while full, unaligned target
        repeat (5) cyc(1'b0, 32'h0, 1'b1);
        cyc(1'b1, 32'h0000_0103, 1'b0);
        repeat (3) cyc(1'b0, 32'h0, 1'b0);
        // redirect and stall together with two entries queued
        cyc(1'b1, 32'h0000_0200, 1'b0);
        repeat (2) cyc(1'b0, 32'h0, 1'b1);
        cyc(1'b1, 32'h0000_0300, 1'b1);
        repeat (2) cyc(1'b0, 32'h0, 1'b0);
        // asynchronous reset mid-stream
        repeat (3) cyc(1'b0, 32'h0, 1'b1);
        #2 Rst = 1'b1;
        #1;
        check("async_count", 32'(Count), 32'h0);
        check("async_valid", 32'(Valid_de), 32'h0);
        check("async_inst", Inst_de, 32'h13);
        check("async_pc", PC_de, 32'h0);
        check("async_pcinc", PCInc_de, 32'h0);
        check("async_addr", IMemAddr, 32'h0);
        model_reset();
        @(posedge Clk);
        #1 Rst = 1'b0;
        repeat (3) cyc(1'b0, 32'h0, 1'b0);
        // address wrap at 2^32
        cyc(1'b1, 32'hFFFF_FFFC, 1'b0);
        repeat (4) cyc(1'b0, 32'h0, 1'b0);
        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic        r, s;
            logic [31:0] rp;
            r  = ($urandom_range(0, 7) == 0);
            s  = ($urandom_range(0, 2) == 0);
            rp = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
            cyc(r, rp, s);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
